// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and frame-length constants,
// kept here so a future receiver can reuse them.
package uart_pkg;

   localparam int unsigned DATA_BITS     = 8;
   localparam int unsigned STOP_BITS_ONE = 1;
   localparam int unsigned STOP_BITS_TWO = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_e;

   function automatic bit stop_bits_legal(input int unsigned n);
      return (n == STOP_BITS_ONE) || (n == STOP_BITS_TWO);
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake plus serial-line status of the UART transmitter.
// master drives the byte stream, slave is the transmitter.
interface uart_tx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] data_i;
   logic                 valid_i;
   logic                 ready_o;
   logic                 tx_o;
   logic                 busy_o;

   modport master (output data_i, output valid_i, input ready_o, input tx_o, input busy_o);
   modport slave  (input data_i, input valid_i, output ready_o, output tx_o, output busy_o);

endinterface

// File: rtl/uart_baud_cnt.sv
// Reloadable bit-period down-counter; expire_o is high while the count sits at zero.
module uart_baud_cnt #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   output logic expire_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = RELOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter with optional parity and one or two stop bits.
// tx_o is registered; the start bit appears the cycle after acceptance.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input logic      clk_i,
   input logic      rst_i,
   uart_tx_if.slave bus
);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
   end
   if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   uart_tx_state_e       state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]           idx_q, idx_d;
   logic                 tx_q, tx_d;
   logic                 par_q, par_d;
   logic                 cnt_expire;
   logic                 accept;
   logic                 bit_end;

   assign accept  = bus.valid_i && (state_q == IDLE);
   assign bit_end = cnt_expire && (state_q != IDLE);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (accept || bit_end),
      .expire_o(cnt_expire)
   );

   // Parity accumulates each captured bit as it is shifted onto the line.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (accept) begin
               state_d = START;
               shift_d = bus.data_i;
               idx_d   = '0;
               par_d   = (PARITY_ODD != 0);
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
               tx_d    = shift_q[0];
               par_d   = par_q ^ shift_q[0];
               shift_d = shift_q >> 1;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == 3'(DATA_BITS - 1)) begin
                  idx_d = '0;
                  if (PARITY_EN != 0) begin
                     state_d = PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shift_q[0];
                  par_d   = par_q ^ shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               idx_d   = '0;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               if (idx_q == 3'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         par_q   <= par_d;
      end
   end

   assign bus.ready_o = (state_q == IDLE);
   assign bus.busy_o  = (state_q != IDLE);
   assign bus.tx_o    = tx_q;

endmodule
